pipelined_shifter: RTL



---
 rtl/pipelined_shifter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: log-stage barrel shifter (SLL/SRL/SRA/ROR), one register
// per shift-amount bit, valid/ready handshake with whole-pipe stall and tag.
// Ports: clk, rst (async, active-high), flush (sync clear),
//   in_valid/in_ready/in_op/in_data/in_shamt/in_tag (operation in),
//   out_valid/out_ready/out_data/out_tag (result out).
// Optional macro SHIFTER_FLAGS_EN adds out_zero and out_carry.
module pipelined_shifter #(
   parameter int WIDTH = 32,
   parameter int SHW   = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
`ifdef SHIFTER_FLAGS_EN
   ,
   output logic             out_zero,
   output logic             out_carry
`endif
);

   localparam int L = $clog2(WIDTH);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   typedef struct packed {
      logic             v;
      logic [WIDTH-1:0] data;
      logic [1:0]       op;
      logic [TAG_W-1:0] tag;
      logic             sat;
      logic             sgn;
      logic [L-1:0]     sh;
`ifdef SHIFTER_FLAGS_EN
      logic             cy;
`endif
   } stage_t;

   stage_t st_q [L];
   stage_t st_d [L];
   stage_t src  [L];
   stage_t in_s;

   logic adv;
   logic over;
   logic eq_w;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // over: shamt >= WIDTH; eq_w: shamt == WIDTH exactly
   assign over = (in_shamt >> L) != '0;
   assign eq_w = ((in_shamt >> L) == SHW'(1)) &&
                 (in_shamt[L-1:0] == '0);

   // Acceptance: saturation resolved here, so stages never shift a
   // saturated operand.
   always_comb begin
      in_s      = '0;
      in_s.v    = in_valid && in_ready;
      in_s.data = in_data;
      in_s.op   = in_op;
      in_s.tag  = in_tag;
      in_s.sgn  = in_data[WIDTH-1];
      in_s.sh   = in_shamt[L-1:0];
      in_s.sat  = over && (in_op != OP_ROR);
      if (in_s.sat) begin
         if (in_op == OP_SRA && in_s.sgn)
            in_s.data = '1;
         else
            in_s.data = '0;
      end
`ifdef SHIFTER_FLAGS_EN
      if (in_s.sat) begin
         unique case (in_op)
            OP_SLL:  in_s.cy = eq_w && in_data[0];
            OP_SRL:  in_s.cy = eq_w && in_data[WIDTH-1];
            default: in_s.cy = in_s.sgn;
         endcase
      end
`endif
   end

   // Stage k shifts by 2^(L-1-k). The carry is overwritten by each stage
   // that actually shifts, so the last shifting stage leaves the final
   // shifted-out bit (for ROR that is also result[WIDTH-1]).
   always_comb begin
      logic [2*WIDTH-1:0] wide;
      logic [WIDTH-1:0]   hi;
      int                 b;
      src[0] = in_s;
      for (int k = 1; k < L; k++)
         src[k] = st_q[k-1];
      for (int k = 0; k < L; k++) begin
         b        = 1 << (L - 1 - k);
         st_d[k]  = src[k];
         hi       = '0;
         wide     = '0;
         if (!src[k].sat && src[k].sh[L-1-k]) begin
            if (src[k].op == OP_SLL) begin
               st_d[k].data = src[k].data << b;
`ifdef SHIFTER_FLAGS_EN
               st_d[k].cy = src[k].data[WIDTH-b];
`endif
            end else begin
               if (src[k].op == OP_ROR)
                  hi = src[k].data;
               else if (src[k].op == OP_SRA)
                  hi = {WIDTH{src[k].sgn}};
               wide = {hi, src[k].data} >> b;
               st_d[k].data = wide[WIDTH-1:0];
`ifdef SHIFTER_FLAGS_EN
               st_d[k].cy = src[k].data[b-1];
`endif
            end
         end
      end
   end

`ifdef SHIFTER_FLAGS_EN
   logic zero_q;
   logic zero_d;

   assign zero_d = (st_d[L-1].data == '0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < L; k++)
            st_q[k] <= '0;
`ifdef SHIFTER_FLAGS_EN
         zero_q <= 1'b0;
`endif
      end else begin
         if (adv) begin
            for (int k = 0; k < L; k++)
               st_q[k] <= st_d[k];
`ifdef SHIFTER_FLAGS_EN
            zero_q <= zero_d;
`endif
         end
         if (flush) begin
            for (int k = 0; k < L; k++)
               st_q[k].v <= 1'b0;
         end
      end
   end

   assign out_valid = st_q[L-1].v;
   assign out_data  = st_q[L-1].data;
   assign out_tag   = st_q[L-1].tag;
`ifdef SHIFTER_FLAGS_EN
   assign out_zero  = zero_q;
   assign out_carry = st_q[L-1].cy;
`endif

endmodule
